pipe_addsub: RTL and testbench

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub.sv | 127 ++++++++++++
 tb/tb_pipe_addsub.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined unsigned add/subtract/accumulate unit with a valid/ready handshake.
// A full-pipeline stall holds every stage while the sink back-pressures the result.
module pipe_addsub #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2,
   parameter bit SAT    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   y,
   output logic             ovf
);
   localparam int RW = WIDTH + 1;

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_ACC = 2'b10;
   localparam logic [1:0] MODE_CLR = 2'b11;

   logic          advance_s;
   logic          accept_s;
   logic          borrow_s;
   logic          res_ovf_s;
   logic [RW-1:0] diff_s;
   logic [RW-1:0] res_y_s;
   logic [RW-1:0] acc_r;
   logic [RW-1:0] acc_nxt_s;
   logic [RW:0]   acc_sum_s;

   logic [RW-1:0] stage_y_r   [STAGES];
   logic          stage_ovf_r [STAGES];
   logic          stage_vld_r [STAGES];

   // Reset forces ready high so nothing appears blocked while state is cleared.
   assign advance_s = rst | ~(stage_vld_r[STAGES-1] & ~out_ready);
   assign accept_s  = in_valid & advance_s & ~rst;
   assign in_ready  = advance_s;

   assign borrow_s  = (a < b);
   assign diff_s    = {1'b0, a} - {1'b0, b};
   assign acc_sum_s = {1'b0, acc_r} + {2'b00, a};

   // Operation decode: result, flag and the accumulator value committed on acceptance.
   always_comb begin
      res_y_s   = '0;
      res_ovf_s = 1'b0;
      acc_nxt_s = acc_r;
      case (mode)
         MODE_ADD: begin
            res_y_s = {1'b0, a} + {1'b0, b};
         end
         MODE_SUB: begin
            res_ovf_s = borrow_s;
            if (SAT && borrow_s) begin
               res_y_s = '0;
            end else begin
               res_y_s = diff_s;
            end
         end
         MODE_ACC: begin
            res_ovf_s = acc_sum_s[RW];
            if (SAT && acc_sum_s[RW]) begin
               acc_nxt_s = '1;
            end else begin
               acc_nxt_s = acc_sum_s[RW-1:0];
            end
            res_y_s = acc_nxt_s;
         end
         MODE_CLR: begin
            acc_nxt_s = '0;
         end
         default: begin
            res_y_s   = '0;
            res_ovf_s = 1'b0;
         end
      endcase
   end

   // Accumulator updates at acceptance so a following ACC sees it regardless of depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= '0;
      end else if (accept_s) begin
         acc_r <= acc_nxt_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   // Result pipeline: all stages shift together or hold together.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_y_r[i]   <= '0;
            stage_ovf_r[i] <= 1'b0;
            stage_vld_r[i] <= 1'b0;
         end
      end else if (advance_s) begin
         stage_vld_r[0] <= accept_s;
         stage_ovf_r[0] <= accept_s & res_ovf_s;
         stage_y_r[0]   <= accept_s ? res_y_s : '0;
         for (int i = 1; i < STAGES; i++) begin
            stage_vld_r[i] <= stage_vld_r[i-1];
            stage_ovf_r[i] <= stage_ovf_r[i-1];
            stage_y_r[i]   <= stage_y_r[i-1];
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            stage_y_r[i]   <= stage_y_r[i];
            stage_ovf_r[i] <= stage_ovf_r[i];
            stage_vld_r[i] <= stage_vld_r[i];
         end
      end
   end

   assign out_valid = stage_vld_r[STAGES-1];
   assign y         = stage_y_r[STAGES-1];
   assign ovf       = stage_ovf_r[STAGES-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: four configurations share one stimulus stream; directed
// vectors target the STAGES=2 pair, a random stream checks all against a model.
module tb_pipe_addsub;
   localparam int NR = 300;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       out_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic [1:0] mode;

   logic       ir_o  [4];
   logic       ov_o  [4];
   logic [4:0] y_o   [4];
   logic       ovf_o [4];

   int n_vec = 0;
   int n_err = 0;
   int stg [4];
   int sat [4];
   int acc_m [4];

   typedef struct {
      logic [1:0] md;
      int a; int b;
      int y0; int o0;
      int y1; int o1;
   } vec_t;

   typedef struct {
      bit v;
      int y;
      int o;
   } hist_t;

   vec_t  tbl [14];
   hist_t hist [4][NR+8];
   int    sy0 [4];
   int    sy1 [4];
   int    so  [4];

   pipe_addsub #(.WIDTH(4), .STAGES(1), .SAT(1'b0)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_o[0]), .a(a), .b(b),
      .mode(mode), .out_valid(ov_o[0]), .out_ready(out_ready), .y(y_o[0]), .ovf(ovf_o[0]));
   pipe_addsub #(.WIDTH(4), .STAGES(2), .SAT(1'b0)) u_s2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_o[1]), .a(a), .b(b),
      .mode(mode), .out_valid(ov_o[1]), .out_ready(out_ready), .y(y_o[1]), .ovf(ovf_o[1]));
   pipe_addsub #(.WIDTH(4), .STAGES(2), .SAT(1'b1)) u_s2s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_o[2]), .a(a), .b(b),
      .mode(mode), .out_valid(ov_o[2]), .out_ready(out_ready), .y(y_o[2]), .ovf(ovf_o[2]));
   pipe_addsub #(.WIDTH(4), .STAGES(4), .SAT(1'b0)) u_s4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_o[3]), .a(a), .b(b),
      .mode(mode), .out_valid(ov_o[3]), .out_ready(out_ready), .y(y_o[3]), .ovf(ovf_o[3]));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference semantics on plain integers, 5-bit result space (WIDTH=4).
   function automatic void ref_op(input int md, input int ia, input int ib, input int isat,
                                  inout int acc, output int ry, output int ro);
      int m;
      int s;
      m  = 32;
      ry = 0;
      ro = 0;
      case (md)
         0: ry = ia + ib;
         1: begin
            if (ia >= ib) ry = ia - ib;
            else begin
               ro = 1;
               ry = (isat != 0) ? 0 : ia - ib + m;
            end
         end
         2: begin
            s = acc + ia;
            if (s >= m) begin
               ro  = 1;
               acc = (isat != 0) ? m - 1 : s - m;
            end else acc = s;
            ry = acc;
         end
         default: acc = 0;
      endcase
   endfunction

   initial begin
      int yy;
      int oo;
      int s;
      bit v;

      stg = '{1, 2, 2, 4};
      sat = '{0, 0, 1, 0};
      tbl[0]  = '{2'b00, 15, 15, 30, 0, 30, 0};
      tbl[1]  = '{2'b01,  3,  5, 30, 1,  0, 1};
      tbl[2]  = '{2'b01,  9,  9,  0, 0,  0, 0};
      tbl[3]  = '{2'b01, 15,  0, 15, 0, 15, 0};
      tbl[4]  = '{2'b00,  7,  8, 15, 0, 15, 0};
      tbl[5]  = '{2'b00,  0,  0,  0, 0,  0, 0};
      tbl[6]  = '{2'b10,  5,  9,  5, 0,  5, 0};
      tbl[7]  = '{2'b10, 15,  3, 20, 0, 20, 0};
      tbl[8]  = '{2'b00,  1,  1,  2, 0,  2, 0};
      tbl[9]  = '{2'b10, 15,  0,  3, 1, 31, 1};
      tbl[10] = '{2'b10,  1,  0,  4, 0, 31, 1};
      tbl[11] = '{2'b11,  5,  6,  0, 0,  0, 0};
      tbl[12] = '{2'b10,  2,  0,  2, 0,  2, 0};
      tbl[13] = '{2'b01,  0, 15, 17, 1,  0, 1};
      sy0 = '{0, 15, 30, 13};
      sy1 = '{0, 15, 30, 31};
      so  = '{0, 0, 0, 1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 4'd0; b = 4'd0; mode = 2'b00;
      step();
      chk("rst_in_ready", int'(ir_o[1]), 1);
      step();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_vld%0d", k), int'(ov_o[k]), 0);
         chk($sformatf("rst_y%0d", k), int'(y_o[k]), 0);
         chk($sformatf("rst_ovf%0d", k), int'(ovf_o[k]), 0);
         chk($sformatf("rst_rdy%0d", k), int'(ir_o[k]), 1);
      end

      // Single operations, latency exactly two cycles.
      for (int i = 0; i < 14; i++) begin
         mode = tbl[i].md; a = tbl[i].a[3:0]; b = tbl[i].b[3:0]; in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         chk($sformatf("tbl%0d_early", i), int'(ov_o[1]), 0);
         step();
         chk($sformatf("tbl%0d_vld", i), int'(ov_o[1]), 1);
         chk($sformatf("tbl%0d_y", i), int'(y_o[1]), tbl[i].y0);
         chk($sformatf("tbl%0d_ovf", i), int'(ovf_o[1]), tbl[i].o0);
         chk($sformatf("tbl%0d_y_sat", i), int'(y_o[2]), tbl[i].y1);
         chk($sformatf("tbl%0d_ovf_sat", i), int'(ovf_o[2]), tbl[i].o1);
      end

      // CLR then three back-to-back ACC a=15.
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin
            mode = 2'b11; a = 4'd0; in_valid = 1'b1;
         end else if (i < 4) begin
            mode = 2'b10; a = 4'd15; b = 4'($urandom_range(0, 15)); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (i >= 1) begin
            chk($sformatf("acc%0d_vld", i - 1), int'(ov_o[1]), 1);
            chk($sformatf("acc%0d_y", i - 1), int'(y_o[1]), sy0[i-1]);
            chk($sformatf("acc%0d_ovf", i - 1), int'(ovf_o[1]), so[i-1]);
            chk($sformatf("acc%0d_y_sat", i - 1), int'(y_o[2]), sy1[i-1]);
            chk($sformatf("acc%0d_ovf_sat", i - 1), int'(ovf_o[2]), so[i-1]);
         end
      end
      step();

      // Back-pressure: two ops fill the pipe, a third waits until the sink is ready.
      out_ready = 1'b0; mode = 2'b00; a = 4'd1; b = 4'd2; in_valid = 1'b1;
      #1;
      chk("stall_rdy0", int'(ir_o[1]), 1);
      step();
      a = 4'd4; b = 4'd4;
      step();
      for (int s2 = 0; s2 < 5; s2++) begin
         mode = 2'($urandom_range(0, 1)); a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
         #1;
         chk($sformatf("stall%0d_vld", s2), int'(ov_o[1]), 1);
         chk($sformatf("stall%0d_y", s2), int'(y_o[1]), 3);
         chk($sformatf("stall%0d_rdy", s2), int'(ir_o[1]), 0);
         step();
      end
      mode = 2'b01; a = 4'd9; b = 4'd2; out_ready = 1'b1;
      #1;
      chk("release_rdy", int'(ir_o[1]), 1);
      chk("release_y0", int'(y_o[1]), 3);
      step();
      in_valid = 1'b0;
      chk("drain_vld1", int'(ov_o[1]), 1);
      chk("drain_y1", int'(y_o[1]), 8);
      step();
      chk("drain_vld2", int'(ov_o[1]), 1);
      chk("drain_y2", int'(y_o[1]), 7);
      chk("drain_ovf2", int'(ovf_o[1]), 0);
      step();
      chk("drain_empty", int'(ov_o[1]), 0);

      // Reset with two operations in flight and an ACC offered during reset.
      mode = 2'b00; a = 4'd1; b = 4'd1; in_valid = 1'b1;
      step();
      a = 4'd2; b = 4'd2;
      step();
      rst = 1'b1; out_ready = 1'b0; mode = 2'b10; a = 4'd7; in_valid = 1'b1;
      #1;
      chk("midrst_rdy", int'(ir_o[1]), 1);
      chk("midrst_rdy_sat", int'(ir_o[2]), 1);
      step();
      rst = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
      #1;
      for (int k = 1; k < 3; k++) begin
         chk($sformatf("postrst_vld%0d", k), int'(ov_o[k]), 0);
         chk($sformatf("postrst_y%0d", k), int'(y_o[k]), 0);
         chk($sformatf("postrst_ovf%0d", k), int'(ovf_o[k]), 0);
         chk($sformatf("postrst_rdy%0d", k), int'(ir_o[k]), 1);
      end
      mode = 2'b10; a = 4'd1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      for (int k = 1; k < 3; k++) begin
         chk($sformatf("postrst_acc_vld%0d", k), int'(ov_o[k]), 1);
         chk($sformatf("postrst_acc_y%0d", k), int'(y_o[k]), 1);
         chk($sformatf("postrst_acc_ovf%0d", k), int'(ovf_o[k]), 0);
      end

      // Random stream, sink always ready, every configuration against the model.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) acc_m[k] = 0;
      for (int c = 0; c < NR + 6; c++) begin
         for (int k = 0; k < 4; k++) begin
            s = stg[k];
            if (c >= s && hist[k][c-s].v) begin
               chk($sformatf("rnd_c%0d_k%0d_vld", c, k), int'(ov_o[k]), 1);
               chk($sformatf("rnd_c%0d_k%0d_y", c, k), int'(y_o[k]), hist[k][c-s].y);
               chk($sformatf("rnd_c%0d_k%0d_ovf", c, k), int'(ovf_o[k]), hist[k][c-s].o);
            end else begin
               chk($sformatf("rnd_c%0d_k%0d_vld", c, k), int'(ov_o[k]), 0);
            end
            chk($sformatf("rnd_c%0d_k%0d_rdy", c, k), int'(ir_o[k]), 1);
         end
         v = (c < NR) && ($urandom_range(0, 3) != 0);
         mode = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         in_valid = v;
         for (int k = 0; k < 4; k++) begin
            if (v) begin
               ref_op(int'(mode), int'(a), int'(b), sat[k], acc_m[k], yy, oo);
               hist[k][c] = '{1'b1, yy, oo};
            end else begin
               hist[k][c] = '{1'b0, 0, 0};
            end
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
